// File: rtl/mem_pkg.sv
// mem_pkg: shared state encoding and lane/word widths for the MEM-stage store path
package mem_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  typedef enum logic [2:0] {IDLE, READ, WAIT, MERGE, WRITE, ERR} state_t;
endpackage

// File: rtl/byte_merge.sv
// byte_merge: replace one byte lane of a word, other lanes pass through
module byte_merge
  import mem_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  input  logic [BYTE_W-1:0] i_byte,
  input  logic [1:0]        i_lane,
  output logic [WORD_W-1:0] o_word
);
  for (genvar i = 0; i < WORD_W / BYTE_W; i++) begin : g_lane
    assign o_word[i*BYTE_W +: BYTE_W] = (i_lane == 2'(i)) ? i_byte : i_word[i*BYTE_W +: BYTE_W];
  end
endmodule

// File: rtl/mem_store_unit.sv
// mem_store_unit: word stores write directly, byte stores do read-modify-write
// All outputs are registered from the next state so they line up with the state they describe.
module mem_store_unit
  import mem_pkg::*;
#(
  parameter int RD_LAT   = 1,
  parameter bit LANE_SEL = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_st_req,
  output logic              o_st_ready,
  input  logic              i_sel_sb,
  input  logic [WORD_W-1:0] i_st_addr,
  input  logic [WORD_W-1:0] i_st_data,
  output logic              o_st_done,
  output logic              o_st_err,
  output logic [WORD_W-1:0] o_mem_addr,
  output logic              o_mem_re,
  input  logic [WORD_W-1:0] i_mem_rdata,
  output logic              o_mem_we,
  output logic [WORD_W-1:0] o_mem_wdata
);
  state_t r_state, w_next;
  logic [1:0] r_cnt, r_lane;
  logic [BYTE_W-1:0] r_byte;
  logic [WORD_W-1:0] r_merge, w_merged;
  logic w_accept;
  assign w_accept = i_st_req && o_st_ready;
  byte_merge u_merge (
    .i_word (r_merge),
    .i_byte (r_byte),
    .i_lane (r_lane),
    .o_word (w_merged)
  );
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = !w_accept ? IDLE : i_sel_sb ? READ : (i_st_addr[1:0] == 2'b00) ? WRITE : ERR;
      READ:    w_next = WAIT;
      WAIT:    w_next = (r_cnt == 2'd0) ? MERGE : WAIT;
      MERGE:   w_next = WRITE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_lane      <= '0;
      r_byte      <= '0;
      r_merge     <= '0;
      o_st_ready  <= 1'b1;
      o_st_done   <= 1'b0;
      o_st_err    <= 1'b0;
      o_mem_re    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      r_state    <= w_next;
      o_st_ready <= w_next == IDLE;
      o_mem_re   <= w_next == READ;
      o_mem_we   <= w_next == WRITE;
      o_st_done  <= w_next == WRITE;
      o_st_err   <= w_next == ERR;
      if (w_accept) begin
        r_lane     <= LANE_SEL ? i_st_addr[1:0] : 2'b00;
        r_byte     <= i_st_data[BYTE_W-1:0];
        o_mem_addr <= {i_st_addr[WORD_W-1:2], 2'b00};
      end
      if (r_state == IDLE && w_next == WRITE) o_mem_wdata <= i_st_data;
      // Counter is loaded so that it reaches zero in the cycle read data is valid.
      if (r_state == READ) r_cnt <= 2'(RD_LAT - 1);
      else if (r_state == WAIT && r_cnt != 2'd0) r_cnt <= r_cnt - 2'd1;
      if (r_state == WAIT && r_cnt == 2'd0) r_merge <= i_mem_rdata;
      if (r_state == MERGE) o_mem_wdata <= w_merged;
    end
  end
endmodule

// File: tb/tb_mem_store_unit.sv
// tb_mem_store_unit: three configurations (RD_LAT/LANE_SEL) driven by a vector table plus corner sequences
module tb_mem_store_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic sel_sb;
  logic [31:0] st_addr, st_data, mem_word;
  logic [2:0] req, ready, done, err, re, we;
  logic [2:0][31:0] maddr, wdata, rdata;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam bit LS  = (g == 1) ? 1'b0 : 1'b1;
    logic [3:0] vld = '0;
    always @(posedge clk) vld <= {vld[2:0], re[g]};
    assign rdata[g] = vld[LAT-1] ? mem_word : 32'hBAD0BAD0;
    mem_store_unit #(.RD_LAT(LAT), .LANE_SEL(LS)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_st_req    (req[g]),
      .o_st_ready  (ready[g]),
      .i_sel_sb    (sel_sb),
      .i_st_addr   (st_addr),
      .i_st_data   (st_data),
      .o_st_done   (done[g]),
      .o_st_err    (err[g]),
      .o_mem_addr  (maddr[g]),
      .o_mem_re    (re[g]),
      .i_mem_rdata (rdata[g]),
      .o_mem_we    (we[g]),
      .o_mem_wdata (wdata[g])
    );
  end
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, got, exp);
    end
  endtask
  typedef struct {
    int d;
    logic sb;
    logic [31:0] addr, data, mem, wd;
    int c_re, c_we, c_err, c_rdy;
  } vec_t;
  typedef struct {
    int c_re, c_we, c_done, c_err, c_rdy, n_we, n_re, both;
    logic [31:0] wd, ma;
  } res_t;
  task automatic op(input int d, input logic sb, input logic [31:0] a, input logic [31:0] dat,
                    input logic [31:0] mw, output res_t r);
    r = '{default: 0};
    @(negedge clk);
    sel_sb = sb; st_addr = a; st_data = dat; mem_word = mw; req[d] = 1'b1;
    @(posedge clk); #1;
    req[d] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (re[d]) begin r.n_re++; if (r.c_re == 0) r.c_re = k; end
      if (we[d]) begin r.n_we++; if (r.c_we == 0) begin r.c_we = k; r.wd = wdata[d]; end end
      if ((re[d] || we[d]) && r.ma == 0) r.ma = maddr[d];
      if (re[d] && we[d]) r.both++;
      if (done[d] && r.c_done == 0) r.c_done = k;
      if (err[d] && r.c_err == 0) r.c_err = k;
      if (ready[d] && r.c_rdy == 0) r.c_rdy = k;
      @(posedge clk); #1;
    end
  endtask
  vec_t v[10];
  res_t r;
  logic [4:0] pat;
  int nwe;
  initial begin
    v[0] = '{0, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        32'hDEADBEEF, 0, 1, 0, 2};
    v[1] = '{0, 1'b1, 32'h20, 32'h000000AB, 32'h11223344, 32'h112233AB, 1, 4, 0, 5};
    v[2] = '{0, 1'b1, 32'h21, 32'h000000AB, 32'h11223344, 32'h1122AB44, 1, 4, 0, 5};
    v[3] = '{0, 1'b1, 32'h22, 32'h999999AB, 32'h11223344, 32'h11AB3344, 1, 4, 0, 5};
    v[4] = '{0, 1'b1, 32'h23, 32'h000000AB, 32'h11223344, 32'hAB223344, 1, 4, 0, 5};
    v[5] = '{1, 1'b1, 32'h23, 32'h000000CD, 32'hFFFFFFFF, 32'hFFFFFFCD, 1, 4, 0, 5};
    v[6] = '{0, 1'b0, 32'h06, 32'h12345678, 32'h0,        32'h0,        0, 0, 1, 2};
    v[7] = '{2, 1'b1, 32'h41, 32'h0000005A, 32'h11223344, 32'h11225A44, 1, 6, 0, 7};
    v[8] = '{2, 1'b0, 32'h80, 32'h12345678, 32'h0,        32'h12345678, 0, 1, 0, 2};
    v[9] = '{2, 1'b0, 32'h03, 32'h12345678, 32'h0,        32'h0,        0, 0, 1, 2};
    rst_n = 1'b0; req = '0; sel_sb = 1'b0; st_addr = '0; st_data = '0; mem_word = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_flags_%0d", d), {27'b0, ready[d], done[d], err[d], re[d], we[d]}, 32'h10);
      chk($sformatf("reset_addr_%0d", d), maddr[d], 32'h0);
      chk($sformatf("reset_wdata_%0d", d), wdata[d], 32'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      op(v[i].d, v[i].sb, v[i].addr, v[i].data, v[i].mem, r);
      chk($sformatf("v%0d_re_cyc", i), r.c_re, v[i].c_re);
      chk($sformatf("v%0d_we_cyc", i), r.c_we, v[i].c_we);
      chk($sformatf("v%0d_done_cyc", i), r.c_done, v[i].c_we);
      chk($sformatf("v%0d_err_cyc", i), r.c_err, v[i].c_err);
      chk($sformatf("v%0d_ready_cyc", i), r.c_rdy, v[i].c_rdy);
      chk($sformatf("v%0d_we_count", i), r.n_we, (v[i].c_we != 0) ? 1 : 0);
      chk($sformatf("v%0d_re_count", i), r.n_re, v[i].c_re);
      chk($sformatf("v%0d_re_we_overlap", i), r.both, 0);
      if (v[i].c_we != 0) begin
        chk($sformatf("v%0d_wdata", i), r.wd, v[i].wd);
        chk($sformatf("v%0d_maddr", i), r.ma, {v[i].addr[31:2], 2'b00});
      end
      if (i == 5) chk("v5_load_byte_roundtrip", {24'h0, r.wd[7:0]}, 32'hCD);
    end
    // back-to-back: request held high through the busy cycle
    @(negedge clk);
    sel_sb = 1'b0; st_addr = 32'h30; st_data = 32'hCAFEF00D; req[0] = 1'b1;
    @(posedge clk); #1;
    pat = '0;
    for (int k = 1; k <= 5; k++) begin
      pat[k-1] = we[0] & done[0];
      if (k == 3) req[0] = 1'b0;
      @(posedge clk); #1;
    end
    chk("b2b_we_pattern", {27'b0, pat}, 32'h05);
    // reset asserted while waiting for read data
    @(negedge clk);
    sel_sb = 1'b1; st_addr = 32'h42; st_data = 32'h77; mem_word = 32'h11223344; req[2] = 1'b1;
    @(posedge clk); #1;
    req[2] = 1'b0;
    chk("rst_mid_re", {31'b0, re[2]}, 32'h1);
    @(posedge clk); #1;
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_flags", {27'b0, ready[2], done[2], err[2], re[2], we[2]}, 32'h10);
    chk("rst_mid_addr", maddr[2], 32'h0);
    chk("rst_mid_wdata", wdata[2], 32'h0);
    @(negedge clk) rst_n = 1'b1;
    nwe = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (we[2]) nwe++;
    end
    chk("rst_mid_no_write", nwe, 0);
    op(2, 1'b0, 32'h84, 32'h0BADF00D, 32'h0, r);
    chk("post_rst_we_cyc", r.c_we, 1);
    chk("post_rst_wdata", r.wd, 32'h0BADF00D);
    chk("post_rst_maddr", r.ma, 32'h84);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
